cell_mem_scheduler: RTL and testbench



---
 rtl/cell_mem_pkg.sv | 21 ++
 rtl/cell_bank_port_mux.sv | 86 ++++++++
 rtl/cell_mem_scheduler.sv | 139 +++++++++++++
 tb/tb_cell_mem_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_mem_pkg.sv
// Shared types and constants for the cell RAM scheduler: FSM states and bank indices.
package cell_mem_pkg;

  localparam int unsigned DefaultAddrW = 24;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StPreset,
    StManual,
    StEvolve,
    StSwap
  } state_e;

  // Pair A = banks 0/1, pair B = banks 2/3; even bank evolves, odd bank is displayed.
  localparam logic [1:0] BANK_A_EVO  = 2'd0;
  localparam logic [1:0] BANK_A_DISP = 2'd1;
  localparam logic [1:0] BANK_B_EVO  = 2'd2;
  localparam logic [1:0] BANK_B_DISP = 2'd3;

endpackage

// File: rtl/cell_bank_port_mux.sv
// Combinational steering of requester ports onto the four cell banks, and read-data selection.
module cell_bank_port_mux
  import cell_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  state_e                  state,
  input  logic                    sel,
  input  logic                    sel_dly,
  input  logic [ADDR_W-1:0]       init_addr,
  input  logic                    init_wdata,
  input  logic                    init_we,
  input  logic [ADDR_W-1:0]       preset_addr,
  input  logic                    preset_wdata,
  input  logic                    preset_we,
  input  logic [ADDR_W-1:0]       man_addr,
  input  logic                    man_wdata,
  input  logic [ADDR_W-1:0]       round_raddr,
  input  logic [ADDR_W-1:0]       round_waddr,
  input  logic                    round_wdata,
  input  logic                    round_we,
  input  logic [ADDR_W-1:0]       vga_addr,
  input  logic [3:0]              bank_q,
  output logic [3:0][ADDR_W-1:0]  bank_addr,
  output logic [3:0]              bank_wren,
  output logic [3:0]              bank_rden,
  output logic [3:0]              bank_wdata,
  output logic                    round_rdata,
  output logic                    vga_rdata
);

  logic [1:0] act_evo, act_disp, idle_evo, idle_disp;
  logic [1:0] rd_evo, rd_disp;

  assign act_evo   = sel ? BANK_B_EVO  : BANK_A_EVO;
  assign act_disp  = sel ? BANK_B_DISP : BANK_A_DISP;
  assign idle_evo  = sel ? BANK_A_EVO  : BANK_B_EVO;
  assign idle_disp = sel ? BANK_A_DISP : BANK_B_DISP;

  always_comb begin
    bank_addr  = '0;
    bank_wren  = '0;
    bank_rden  = '0;
    bank_wdata = '0;
    unique case (state)
      StInit: begin
        for (int k = 0; k < 4; k++) bank_addr[k] = init_addr;
        bank_wdata = {4{init_wdata}};
        bank_wren  = {4{init_we}};
      end
      StPreset: begin
        for (int k = 0; k < 4; k++) bank_addr[k] = preset_addr;
        bank_wdata = {4{preset_wdata}};
        bank_wren  = {4{preset_we}};
      end
      StManual: begin
        for (int k = 0; k < 4; k++) bank_addr[k] = man_addr;
        bank_wdata = {4{man_wdata}};
        bank_wren  = 4'b1111;
      end
      StEvolve: begin
        bank_addr[act_evo]   = round_raddr;
        bank_rden[act_evo]   = 1'b1;
        bank_addr[act_disp]  = vga_addr;
        bank_rden[act_disp]  = 1'b1;
        bank_addr[idle_evo]  = round_waddr;
        bank_addr[idle_disp] = round_waddr;
        bank_wdata[idle_evo]  = round_wdata;
        bank_wdata[idle_disp] = round_wdata;
        bank_wren[idle_evo]   = round_we;
        bank_wren[idle_disp]  = round_we;
      end
      default: begin
        bank_addr[act_disp] = vga_addr;
        bank_rden[act_disp] = 1'b1;
      end
    endcase
  end

  // Read data returns a cycle after the address, so select with the delayed sel.
  assign rd_evo      = sel_dly ? BANK_B_EVO  : BANK_A_EVO;
  assign rd_disp     = sel_dly ? BANK_B_DISP : BANK_A_DISP;
  assign round_rdata = bank_q[rd_evo];
  assign vga_rdata   = (state == StInit) || (state == StPreset) || bank_q[rd_disp];

endmodule

// File: rtl/cell_mem_scheduler.sv
// Generation FSM and arbiter for the four cell RAM banks; swaps pairs only after a full round.
module cell_mem_scheduler
  import cell_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned CELLS  = 480000,
  parameter int unsigned GEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    evo_tick,
  input  logic                    init_req,
  input  logic                    init_done,
  input  logic [ADDR_W-1:0]       init_addr,
  input  logic                    init_wdata,
  input  logic                    init_we,
  input  logic                    preset_req,
  input  logic                    preset_done,
  input  logic [ADDR_W-1:0]       preset_addr,
  input  logic                    preset_wdata,
  input  logic                    preset_we,
  input  logic                    man_req,
  input  logic [ADDR_W-1:0]       man_addr,
  input  logic                    man_wdata,
  output logic                    man_ack,
  output logic                    init_gnt,
  output logic                    preset_gnt,
  output logic                    round_start,
  input  logic                    round_done,
  input  logic [ADDR_W-1:0]       round_raddr,
  input  logic [ADDR_W-1:0]       round_waddr,
  input  logic                    round_wdata,
  input  logic                    round_we,
  output logic                    round_rdata,
  input  logic [ADDR_W-1:0]       vga_addr,
  output logic                    vga_rdata,
  output logic [3:0][ADDR_W-1:0]  bank_addr,
  output logic [3:0]              bank_wren,
  output logic [3:0]              bank_rden,
  output logic [3:0]              bank_wdata,
  input  logic [3:0]              bank_q,
  output logic                    sel,
  output logic [GEN_W-1:0]        gen_count,
  output logic                    tick_overrun
);

  state_e           state_q;
  logic             sel_q, sel_dly_q;
  logic [GEN_W-1:0] gen_count_q;
  logic             tick_pend_q, tick_overrun_q, round_start_q;
  logic [3:0]       mux_wren, mux_rden;

  // CELLS only documents the legal range; addresses pass through unchecked.
  logic unused_cells;
  assign unused_cells = ^32'(CELLS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      sel_q          <= 1'b0;
      sel_dly_q      <= 1'b0;
      gen_count_q    <= '0;
      tick_pend_q    <= 1'b0;
      tick_overrun_q <= 1'b0;
      round_start_q  <= 1'b0;
    end else begin
      sel_dly_q     <= sel_q;
      round_start_q <= 1'b0;
      if (run && evo_tick) begin
        if (tick_pend_q) tick_overrun_q <= 1'b1;
        else             tick_pend_q    <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (init_req)        state_q <= StInit;
          else if (preset_req) state_q <= StPreset;
          else if (man_req)    state_q <= StManual;
          else if (tick_pend_q) begin
            state_q       <= StEvolve;
            tick_pend_q   <= 1'b0;
            round_start_q <= 1'b1;
          end
        end
        StInit:   if (init_done)   state_q <= StIdle;
        StPreset: if (preset_done) state_q <= StIdle;
        StManual: state_q <= StIdle;
        StEvolve: if (round_done)  state_q <= StSwap;
        StSwap: begin
          sel_q       <= ~sel_q;
          gen_count_q <= gen_count_q + GEN_W'(1);
          state_q     <= StIdle;
        end
        default:  state_q <= StIdle;
      endcase
    end
  end

  cell_bank_port_mux #(
    .ADDR_W (ADDR_W)
  ) u_port_mux (
    .state        (state_q),
    .sel          (sel_q),
    .sel_dly      (sel_dly_q),
    .init_addr    (init_addr),
    .init_wdata   (init_wdata),
    .init_we      (init_we),
    .preset_addr  (preset_addr),
    .preset_wdata (preset_wdata),
    .preset_we    (preset_we),
    .man_addr     (man_addr),
    .man_wdata    (man_wdata),
    .round_raddr  (round_raddr),
    .round_waddr  (round_waddr),
    .round_wdata  (round_wdata),
    .round_we     (round_we),
    .vga_addr     (vga_addr),
    .bank_q       (bank_q),
    .bank_addr    (bank_addr),
    .bank_wren    (mux_wren),
    .bank_rden    (mux_rden),
    .bank_wdata   (bank_wdata),
    .round_rdata  (round_rdata),
    .vga_rdata    (vga_rdata)
  );

  // Banks stay quiet in the reset cycle even if the old state was mid-pass.
  assign bank_wren    = rst ? 4'b0000 : mux_wren;
  assign bank_rden    = rst ? 4'b0000 : mux_rden;

  assign init_gnt     = (state_q == StInit);
  assign preset_gnt   = (state_q == StPreset);
  assign man_ack      = (state_q == StManual);
  assign round_start  = round_start_q;
  assign sel          = sel_q;
  assign gen_count    = gen_count_q;
  assign tick_overrun = tick_overrun_q;

endmodule

// File: tb/tb_cell_mem_scheduler.sv
// Directed self-checking bench for cell_mem_scheduler.
module tb_cell_mem_scheduler;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned GEN_W  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   run, evo_tick;
  logic                   init_req, init_done, init_wdata, init_we;
  logic [ADDR_W-1:0]      init_addr;
  logic                   preset_req, preset_done, preset_wdata, preset_we;
  logic [ADDR_W-1:0]      preset_addr;
  logic                   man_req, man_wdata, man_ack;
  logic [ADDR_W-1:0]      man_addr;
  logic                   init_gnt, preset_gnt, round_start, round_done;
  logic [ADDR_W-1:0]      round_raddr, round_waddr, vga_addr;
  logic                   round_wdata, round_we, round_rdata, vga_rdata;
  logic [3:0][ADDR_W-1:0] bank_addr;
  logic [3:0]             bank_wren, bank_rden, bank_wdata, bank_q;
  logic                   sel, tick_overrun;
  logic [GEN_W-1:0]       gen_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cell_mem_scheduler #(
    .ADDR_W (ADDR_W),
    .CELLS  (480000),
    .GEN_W  (GEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .evo_tick     (evo_tick),
    .init_req     (init_req),
    .init_done    (init_done),
    .init_addr    (init_addr),
    .init_wdata   (init_wdata),
    .init_we      (init_we),
    .preset_req   (preset_req),
    .preset_done  (preset_done),
    .preset_addr  (preset_addr),
    .preset_wdata (preset_wdata),
    .preset_we    (preset_we),
    .man_req      (man_req),
    .man_addr     (man_addr),
    .man_wdata    (man_wdata),
    .man_ack      (man_ack),
    .init_gnt     (init_gnt),
    .preset_gnt   (preset_gnt),
    .round_start  (round_start),
    .round_done   (round_done),
    .round_raddr  (round_raddr),
    .round_waddr  (round_waddr),
    .round_wdata  (round_wdata),
    .round_we     (round_we),
    .round_rdata  (round_rdata),
    .vga_addr     (vga_addr),
    .vga_rdata    (vga_rdata),
    .bank_addr    (bank_addr),
    .bank_wren    (bank_wren),
    .bank_rden    (bank_rden),
    .bank_wdata   (bank_wdata),
    .bank_q       (bank_q),
    .sel          (sel),
    .gen_count    (gen_count),
    .tick_overrun (tick_overrun)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs settle before checks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; evo_tick = 1'b0;
    init_req = 1'b0; init_done = 1'b0; init_addr = '0; init_wdata = 1'b0; init_we = 1'b0;
    preset_req = 1'b0; preset_done = 1'b0; preset_addr = '0; preset_wdata = 1'b0;
    preset_we = 1'b0; man_req = 1'b0; man_addr = '0; man_wdata = 1'b0;
    round_done = 1'b0; round_raddr = '0; round_waddr = '0; round_wdata = 1'b0;
    round_we = 1'b0; vga_addr = '0; bank_q = 4'b0000;

    // Reset state
    step(); step();
    settle();
    check_eq("rst_sel", sel, 1'b0);
    check_eq("rst_gen", gen_count, 16'd0);
    check_eq("rst_ovr", tick_overrun, 1'b0);
    check_eq("rst_gnt", {init_gnt, preset_gnt, man_ack, round_start}, 4'b0000);
    check_eq("rst_wren", bank_wren, 4'b0000);
    check_eq("rst_rden", bank_rden, 4'b0000);

    // Init pass: 4 zero writes fanned out to all banks
    rst = 1'b0; init_req = 1'b1; vga_addr = 24'd11;
    settle();
    check_eq("idle_rden", bank_rden, 4'b0010);
    check_eq("idle_vga_addr", bank_addr[1], 24'd11);
    check_eq("idle_gnt", init_gnt, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      init_addr = ADDR_W'(i); init_wdata = 1'b0; init_we = 1'b1;
      init_done = (i == 3);
      if (i == 3) init_req = 1'b0;
      settle();
      check_eq("init_gnt", init_gnt, 1'b1);
      check_eq("init_wren", bank_wren, 4'b1111);
      check_eq("init_rden", bank_rden, 4'b0000);
      check_eq("init_addr", {bank_addr[3], bank_addr[2], bank_addr[1], bank_addr[0]},
               {4{ADDR_W'(i)}});
      check_eq("init_vga1", vga_rdata, 1'b1);
    end
    step();
    init_done = 1'b0; init_we = 1'b0;
    settle();
    check_eq("init_exit_gnt", init_gnt, 1'b0);
    check_eq("init_exit_rden", bank_rden, 4'b0010);
    check_eq("init_exit_sel", sel, 1'b0);

    // First generation
    run = 1'b1; evo_tick = 1'b1;
    step();
    evo_tick = 1'b0;
    settle();
    check_eq("pend_no_start", round_start, 1'b0);
    step();
    // EVOLVE, first cycle; second tick arrives here
    round_waddr = 24'd5; round_wdata = 1'b1; round_we = 1'b1;
    round_raddr = 24'd7; vga_addr = 24'd9; bank_q = 4'b0001; evo_tick = 1'b1;
    settle();
    check_eq("evo_start", round_start, 1'b1);
    check_eq("evo_wren", bank_wren, 4'b1100);
    check_eq("evo_rden", bank_rden, 4'b0011);
    check_eq("evo_waddr", {bank_addr[3], bank_addr[2]}, {24'd5, 24'd5});
    check_eq("evo_raddr", {bank_addr[1], bank_addr[0]}, {24'd9, 24'd7});
    check_eq("evo_wdata", bank_wdata[3:2], 2'b11);
    check_eq("evo_rdata", {round_rdata, vga_rdata}, 2'b10);
    step();
    // third tick while the second is still pending
    round_we = 1'b0;
    settle();
    check_eq("evo_start_once", round_start, 1'b0);
    check_eq("evo_ovr_pre", tick_overrun, 1'b0);
    step();
    evo_tick = 1'b0; round_done = 1'b1;
    settle();
    check_eq("evo_ovr", tick_overrun, 1'b1);
    check_eq("pre_swap_vga_rd", {bank_rden[1], bank_addr[1]}, {1'b1, 24'd9});
    step();
    // SWAP cycle: bank1 returns data for the read issued before the swap
    round_done = 1'b0; bank_q = 4'b0010;
    settle();
    check_eq("swap_sel_old", sel, 1'b0);
    check_eq("swap_vga_bank1", vga_rdata, 1'b1);
    step();
    bank_q = 4'b1000;
    settle();
    check_eq("gen1_sel", sel, 1'b1);
    check_eq("gen1_count", gen_count, 16'd1);
    check_eq("gen1_rden", bank_rden, 4'b1000);
    check_eq("gen1_vga_align", vga_rdata, 1'b0);

    // Second generation (from the queued tick) with a stalled manual write
    step();
    man_req = 1'b1; man_addr = 24'd400300; man_wdata = 1'b1; round_we = 1'b1;
    settle();
    check_eq("gen2_start", round_start, 1'b1);
    check_eq("gen2_wren", bank_wren, 4'b0011);
    check_eq("gen2_vga", vga_rdata, 1'b1);
    check_eq("man_stall_evo", man_ack, 1'b0);
    step();
    round_we = 1'b0; round_done = 1'b1;
    settle();
    check_eq("man_stall_evo2", man_ack, 1'b0);
    step();
    round_done = 1'b0;
    settle();
    check_eq("man_stall_swap", man_ack, 1'b0);
    step();
    settle();
    check_eq("gen2_sel", sel, 1'b0);
    check_eq("gen2_count", gen_count, 16'd2);
    check_eq("man_stall_idle", man_ack, 1'b0);
    step();
    settle();
    check_eq("man_ack", man_ack, 1'b1);
    check_eq("man_wren", bank_wren, 4'b1111);
    check_eq("man_wdata", bank_wdata, 4'b1111);
    check_eq("man_addr", {bank_addr[3], bank_addr[2], bank_addr[1], bank_addr[0]},
             {4{24'd400300}});
    man_req = 1'b0;
    step();
    settle();
    check_eq("man_ack_pulse", man_ack, 1'b0);
    check_eq("no_third_gen_a", round_start, 1'b0);
    step(); step();
    settle();
    check_eq("no_third_gen_b", round_start, 1'b0);
    check_eq("no_third_gen_cnt", gen_count, 16'd2);

    // Preset with an out-of-range address and a stray init_done
    preset_req = 1'b1;
    step();
    preset_addr = 24'd480000; preset_wdata = 1'b1; preset_we = 1'b1; init_done = 1'b1;
    settle();
    check_eq("preset_gnt", preset_gnt, 1'b1);
    check_eq("preset_addr", bank_addr[2], 24'd480000);
    check_eq("preset_wren", bank_wren, 4'b1111);
    step();
    init_done = 1'b0; preset_we = 1'b0; preset_req = 1'b0; preset_done = 1'b1;
    settle();
    check_eq("preset_stray_done", preset_gnt, 1'b1);
    check_eq("preset_vga1", vga_rdata, 1'b1);
    step();
    preset_done = 1'b0;
    settle();
    check_eq("preset_exit", preset_gnt, 1'b0);

    // init_req and man_req together: init wins
    init_req = 1'b1; man_req = 1'b1;
    step();
    settle();
    check_eq("prio_init_gnt", init_gnt, 1'b1);
    check_eq("prio_man_wait", man_ack, 1'b0);
    step();
    init_done = 1'b1; init_req = 1'b0;
    settle();
    check_eq("prio_man_wait2", man_ack, 1'b0);
    step();
    init_done = 1'b0;
    settle();
    check_eq("prio_init_exit", {init_gnt, man_ack}, 2'b00);
    step();
    settle();
    check_eq("prio_man_ack", man_ack, 1'b1);
    man_req = 1'b0;

    // Reach sel=1, then reset mid-EVOLVE
    evo_tick = 1'b1;
    step();
    evo_tick = 1'b0;
    step(); step();
    round_done = 1'b1;
    step();
    round_done = 1'b0;
    step();
    settle();
    check_eq("gen3_sel", sel, 1'b1);
    check_eq("gen3_count", gen_count, 16'd3);
    evo_tick = 1'b1;
    step();
    evo_tick = 1'b0;
    step();
    round_we = 1'b1;
    settle();
    check_eq("gen4_start", round_start, 1'b1);
    check_eq("gen4_wren", bank_wren, 4'b0011);
    step();
    rst = 1'b1;
    settle();
    check_eq("rst_mid_wren", bank_wren, 4'b0000);
    step();
    rst = 1'b0;
    settle();
    check_eq("rst_mid_sel", sel, 1'b0);
    check_eq("rst_mid_gen", gen_count, 16'd0);
    check_eq("rst_mid_ovr", tick_overrun, 1'b0);
    check_eq("rst_mid_idle_wren", bank_wren, 4'b0000);
    check_eq("rst_mid_idle_rden", bank_rden, 4'b0010);
    round_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
